ball_hit_tracker: RTL and testbench
===================================

Name: ball_hit_tracker

Overview:
Sits directly downstream of the bouncing-ball mover and consumes its ball_x/ball_y each frame tick.
- Detects a collision between the ball and the player sprite.
- Tracks remaining lives, an invulnerability window and a survival score.
- Emits a one-cycle respawn pulse that drives the ball mover's clr, so the ball restarts at its start position.
- Asserts game_over when lives are exhausted.

Parameters:
LIVES_INIT, 3, lives loaded at reset (1..7)
HIT_R, 2, collision half-window in pixels; hit when |dx|<=HIT_R and |dy|<=HIT_R
INVULN_TICKS, 60, ticks of invulnerability after a hit (1..255)
SCORE_W, 16, score counter width

Ports:
clk  in  1  system clock
clr  in  1  synchronous active-high reset
tick  in  1  one-cycle frame/move strobe, same cycle the ball mover updates
ball_x  in  7  ball x position from the ball mover
ball_y  in  6  ball y position from the ball mover
player_x  in  7  player sprite centre x
player_y  in  6  player sprite centre y
hit  out  1  one-cycle pulse on an accepted collision
respawn  out  1  one-cycle pulse, same cycle as hit; wired to ball mover clr
invuln  out  1  high while in INVULN state
game_over  out  1  high in OVER state
lives  out  3  remaining lives
score  out  SCORE_W  ticks survived, saturating

Behaviour:
- All state is clocked on posedge clk. clr has priority over every other event.
- Reset values: hit=0, respawn=0, invuln=0, game_over=0, lives=LIVES_INIT, score=0, state=PLAY, timer=0, coll_q=0.
- Collision compare:
  - dx = {1'b0,ball_x} - {1'b0,player_x}, 8-bit signed; dy is the same at 7 bits.
  - Take the absolute values and compare each against HIT_R.
  - The result is registered into coll_q every clk, giving 1 cycle of compare latency.
- The FSM acts only on cycles where tick=1, using coll_q.
- State PLAY:
  - tick & coll_q: pulse hit and respawn for exactly 1 cycle (registered, visible the cycle after the tick edge); lives decrements.
  - If lives was 1, it becomes 0 and the FSM goes to OVER. Otherwise the FSM goes to INVULN with timer=INVULN_TICKS.
  - tick & !coll_q: score += 1, saturating at all-ones.
- State INVULN:
  - invuln=1; collisions are ignored.
  - Each tick: timer -= 1 and score += 1 (saturating).
  - On the tick where the timer reaches 0, go to PLAY; invuln drops the following cycle.
- State OVER:
  - game_over=1. lives, score and timer are frozen; hit and respawn are never asserted. tick is ignored.
  - Only clr leaves OVER.
- Boundary and simultaneous-event rules:
  - Ball and player at the same coordinate: hit.
  - Ball at x=3, player at x=127 (max): dx=-124, no hit. There is no wrap-around in the distance.
  - tick without collision on the same cycle as clr: reset wins and score stays 0.
  - clr mid-INVULN: returns to PLAY immediately with lives restored to LIVES_INIT.
  - The respawn pulse is never longer than 1 cycle, even when coll_q stays high after the respawn. The INVULN window masks the re-hit.
- Lives never underflow below 0.

Optional Feature:
Macro: BALL_HIT_TRACKER_EXTRA_LIFE_EN.
- With the macro defined:
  - Adds parameter EXTRA_LIFE_TICKS (default 1000).
  - Each time score crosses a nonzero multiple of EXTRA_LIFE_TICKS, lives increments, saturating at 7.
  - If a bonus and a hit occur on the same tick, the hit decrement is applied first, then the bonus increment, so the net lives is unchanged. In that case the FSM enters INVULN, not OVER, even when lives was 1.
- Without the macro: lives only decrements.

Decomposition:
- Shared package ball_game_pkg holds:
  - state enum {PLAY, INVULN, OVER}
  - field bounds X_MIN=3, X_MAX=92, Y_MIN=14, Y_MAX=60
  - coordinate widths X_W=7, Y_W=6
- One sub-module: hit_window_cmp, the combinational abs-difference window compare with HIT_R as a parameter. The FSM, counters and coll_q register stay in the top module.

Test Plan:
- Collision pulse and lives: clr, then ball=(50,30), player=(51,31), one tick -> hit=1 and respawn=1 for 1 cycle, lives 3->2, invuln=1, state INVULN.
- Invulnerability window: INVULN_TICKS=4, ball held on the player, 4 ticks -> no further hit, invuln drops after the 4th tick. The 5th tick with collision -> hit, lives 2->1.
- Game over: LIVES_INIT=1, a single colliding tick -> lives=0, game_over=1. A further 10 colliding ticks -> no hit and score frozen. clr -> lives=1, game_over=0.
- Window edges: HIT_R=2, ball=(50,30) with player=(52,28) -> hit; player=(53,30) -> no hit; ball=(3,14) with player=(127,63) -> no hit.
- Score saturation: SCORE_W=4, 20 non-colliding ticks -> score stops at 15. clr together with tick -> score=0.
- With BALL_HIT_TRACKER_EXTRA_LIFE_EN and EXTRA_LIFE_TICKS=5: 5 clean ticks -> lives 3->4. Lives at 7 plus a bonus -> stays 7. Bonus and hit on the same tick with lives=1 -> lives=1, state INVULN.

Source files
------------

// File: rtl/ball_game_pkg.sv
// Shared types and constants for the ball game blocks: FSM states, playfield bounds, coordinate widths.
package ball_game_pkg;

  typedef enum logic [1:0] {PLAY, INVULN, OVER} state_e;

  localparam int X_W   = 7;
  localparam int Y_W   = 6;
  localparam int X_MIN = 3;
  localparam int X_MAX = 92;
  localparam int Y_MIN = 14;
  localparam int Y_MAX = 60;

endpackage

// File: rtl/ball_hit_tracker_hit_window_cmp.sv
// Combinational collision test: |ball - player| <= HIT_R on both axes, no wrap-around.
module hit_window_cmp #(
  parameter int HIT_R = 2,
  parameter int XW    = 7,
  parameter int YW    = 6
) (
  input  logic [XW-1:0] ball_x,
  input  logic [YW-1:0] ball_y,
  input  logic [XW-1:0] player_x,
  input  logic [YW-1:0] player_y,
  output logic          coll
);

  localparam logic [XW:0] RX = HIT_R[XW:0];
  localparam logic [YW:0] RY = HIT_R[YW:0];

  logic signed [XW:0] dx;
  logic signed [YW:0] dy;
  logic        [XW:0] adx;
  logic        [YW:0] ady;

  // One extra bit keeps the difference exact; magnitude never reaches -2^XW.
  assign dx  = $signed({1'b0, ball_x}) - $signed({1'b0, player_x});
  assign dy  = $signed({1'b0, ball_y}) - $signed({1'b0, player_y});
  assign adx = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[YW] ? $unsigned(-dy) : $unsigned(dy);

  assign coll = (adx <= RX) && (ady <= RY);

endmodule

// File: rtl/ball_hit_tracker.sv
// Ball/player hit tracker: lives, invulnerability window, saturating survival score, respawn pulse.
// Optional BALL_HIT_TRACKER_EXTRA_LIFE_EN awards a life each EXTRA_LIFE_TICKS of score.
module ball_hit_tracker
  import ball_game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int HIT_R        = 2,
  parameter int INVULN_TICKS = 60,
  parameter int SCORE_W      = 16
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
  , parameter int EXTRA_LIFE_TICKS = 1000
`endif
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               tick,
  input  logic [X_W-1:0]     ball_x,
  input  logic [Y_W-1:0]     ball_y,
  input  logic [X_W-1:0]     player_x,
  input  logic [Y_W-1:0]     player_y,
  output logic               hit,
  output logic               respawn,
  output logic               invuln,
  output logic               game_over,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score
);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [2:0] lives_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  state_e             state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic               hit_q, hit_d;
  logic               coll_q, coll_d;
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
  logic [SCORE_W-1:0] bonus_score_q, bonus_score_d;
  logic               bonus;
`endif

  hit_window_cmp #(.HIT_R(HIT_R), .XW(X_W), .YW(Y_W)) u_cmp (
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .player_x (player_x),
    .player_y (player_y),
    .coll     (coll_d)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    lives_d   = lives_q;
    score_d   = score_q;
    hit_d     = 1'b0;
    score_inc = sat_inc(score_q);
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
    // Remember the awarded score so a hit tick (score held) cannot award the same multiple twice.
    bonus         = 1'b0;
    bonus_score_d = bonus_score_q;
    if (tick && (state_q != OVER) && (score_inc != score_q) && (score_inc != bonus_score_q) &&
        ((32'(score_inc) % EXTRA_LIFE_TICKS) == 0)) begin
      bonus         = 1'b1;
      bonus_score_d = score_inc;
    end
`endif
    case (state_q)
      PLAY: begin
        if (tick) begin
          if (coll_q) begin
            hit_d   = 1'b1;
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
            if (bonus) lives_d = lives_inc(lives_d);
`endif
            if (lives_d == 3'd0) begin
              state_d = OVER;
            end else begin
              state_d = INVULN;
              timer_d = INVULN_TICKS[7:0];
            end
          end else begin
            score_d = score_inc;
          end
        end
      end
      INVULN: begin
        if (tick) begin
          timer_d = timer_q - 8'd1;
          score_d = score_inc;
          if (timer_d == 8'd0) state_d = PLAY;
        end
      end
      OVER:    ;
      default: state_d = PLAY;
    endcase
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
    if (bonus && !hit_d) lives_d = lives_inc(lives_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= PLAY;
      timer_q <= 8'd0;
      lives_q <= LIVES_INIT[2:0];
      score_q <= '0;
      hit_q   <= 1'b0;
      coll_q  <= 1'b0;
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
      bonus_score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lives_q <= lives_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      coll_q  <= coll_d;
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
      bonus_score_q <= bonus_score_d;
`endif
    end
  end

  assign hit       = hit_q;
  assign respawn   = hit_q;
  assign invuln    = (state_q == INVULN);
  assign game_over = (state_q == OVER);
  assign lives     = lives_q;
  assign score     = score_q;

endmodule

// File: tb/tb_ball_hit_tracker.sv
// Directed bench for ball_hit_tracker; several instances cover different parameter sets.
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
`define EXTRA_P(v) , .EXTRA_LIFE_TICKS(v)
`else
`define EXTRA_P(v)
`endif

module tb_ball_hit_tracker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tick = 1'b0;
  logic [6:0] ball_x = 7'd10, player_x = 7'd100;
  logic [5:0] ball_y = 6'd20, player_y = 6'd50;

  int checks = 0;
  int errors = 0;

  // A: general, short invulnerability
  logic        a_hit, a_resp, a_inv, a_go;
  logic [2:0]  a_lives;
  logic [15:0] a_score;
  // B: single life
  logic        b_hit, b_resp, b_inv, b_go;
  logic [2:0]  b_lives;
  logic [15:0] b_score;
  // C: 4-bit score
  logic        c_hit, c_resp, c_inv, c_go;
  logic [2:0]  c_lives;
  logic [3:0]  c_score;

  always #5 clk = ~clk;

  ball_hit_tracker #(.LIVES_INIT(3), .HIT_R(2), .INVULN_TICKS(4), .SCORE_W(16) `EXTRA_P(1000)) u_a (
    .clk(clk), .clr(clr), .tick(tick), .ball_x(ball_x), .ball_y(ball_y),
    .player_x(player_x), .player_y(player_y), .hit(a_hit), .respawn(a_resp),
    .invuln(a_inv), .game_over(a_go), .lives(a_lives), .score(a_score));

  ball_hit_tracker #(.LIVES_INIT(1), .HIT_R(2), .INVULN_TICKS(60), .SCORE_W(16) `EXTRA_P(5)) u_b (
    .clk(clk), .clr(clr), .tick(tick), .ball_x(ball_x), .ball_y(ball_y),
    .player_x(player_x), .player_y(player_y), .hit(b_hit), .respawn(b_resp),
    .invuln(b_inv), .game_over(b_go), .lives(b_lives), .score(b_score));

  ball_hit_tracker #(.LIVES_INIT(3), .HIT_R(2), .INVULN_TICKS(60), .SCORE_W(4) `EXTRA_P(1000)) u_c (
    .clk(clk), .clr(clr), .tick(tick), .ball_x(ball_x), .ball_y(ball_y),
    .player_x(player_x), .player_y(player_y), .hit(c_hit), .respawn(c_resp),
    .invuln(c_inv), .game_over(c_go), .lives(c_lives), .score(c_score));

`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
  logic        d_hit, d_resp, d_inv, d_go;
  logic [2:0]  d_lives;
  logic [15:0] d_score;
  ball_hit_tracker #(.LIVES_INIT(3), .HIT_R(2), .INVULN_TICKS(4), .SCORE_W(16), .EXTRA_LIFE_TICKS(5)) u_d (
    .clk(clk), .clr(clr), .tick(tick), .ball_x(ball_x), .ball_y(ball_y),
    .player_x(player_x), .player_y(player_y), .hit(d_hit), .respawn(d_resp),
    .invuln(d_inv), .game_over(d_go), .lives(d_lives), .score(d_score));
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick = 1'b0;
    clr  = 1'b1;
    cyc();
    clr  = 1'b0;
  endtask

  task automatic set_pos(input int bx, input int by, input int px, input int py);
    ball_x   = 7'(bx);
    ball_y   = 6'(by);
    player_x = 7'(px);
    player_y = 6'(py);
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    set_pos(10, 20, 100, 50);
    do_reset();
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0d exp 0", a_hit); end
    checks++; if (a_resp !== 1'b0) begin errors++; $display("FAIL reset_respawn got %0d exp 0", a_resp); end
    checks++; if (a_inv !== 1'b0) begin errors++; $display("FAIL reset_invuln got %0d exp 0", a_inv); end
    checks++; if (a_go !== 1'b0) begin errors++; $display("FAIL reset_game_over got %0d exp 0", a_go); end
    checks++; if (a_lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", a_lives); end
    checks++; if (a_score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", a_score); end
    checks++; if (b_lives !== 3'd1) begin errors++; $display("FAIL reset_lives_b got %0d exp 1", b_lives); end
  endtask

  task automatic test_collision();
    do_reset();
    set_pos(50, 30, 51, 31);
    cyc();
    run_ticks(1);
    checks++; if (a_hit !== 1'b1) begin errors++; $display("FAIL coll_hit got %0d exp 1", a_hit); end
    checks++; if (a_resp !== 1'b1) begin errors++; $display("FAIL coll_respawn got %0d exp 1", a_resp); end
    checks++; if (a_lives !== 3'd2) begin errors++; $display("FAIL coll_lives got %0d exp 2", a_lives); end
    checks++; if (a_inv !== 1'b1) begin errors++; $display("FAIL coll_invuln got %0d exp 1", a_inv); end
    cyc();
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL coll_hit_pulse got %0d exp 0", a_hit); end
    checks++; if (a_resp !== 1'b0) begin errors++; $display("FAIL coll_respawn_pulse got %0d exp 0", a_resp); end
  endtask

  task automatic test_invuln();
    int hits;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      run_ticks(1);
      if (a_hit) hits++;
      checks++;
      if (a_inv !== (i < 3)) begin errors++; $display("FAIL invuln_tick%0d got %0d exp %0d", i, a_inv, (i < 3)); end
      cyc();
    end
    checks++; if (hits !== 0) begin errors++; $display("FAIL invuln_rehit got %0d exp 0", hits); end
    checks++; if (a_score !== 16'd4) begin errors++; $display("FAIL invuln_score got %0d exp 4", a_score); end
    checks++; if (a_lives !== 3'd2) begin errors++; $display("FAIL invuln_lives got %0d exp 2", a_lives); end
    run_ticks(1);
    checks++; if (a_hit !== 1'b1) begin errors++; $display("FAIL invuln_5th_hit got %0d exp 1", a_hit); end
    checks++; if (a_lives !== 3'd1) begin errors++; $display("FAIL invuln_5th_lives got %0d exp 1", a_lives); end
    cyc();
    checks++; if (a_resp !== 1'b0) begin errors++; $display("FAIL respawn_len got %0d exp 0", a_resp); end
  endtask

  task automatic test_clr_mid_invuln();
    checks++; if (a_inv !== 1'b1) begin errors++; $display("FAIL mid_invuln_pre got %0d exp 1", a_inv); end
    do_reset();
    checks++; if (a_lives !== 3'd3) begin errors++; $display("FAIL mid_invuln_lives got %0d exp 3", a_lives); end
    checks++; if (a_inv !== 1'b0) begin errors++; $display("FAIL mid_invuln_inv got %0d exp 0", a_inv); end
  endtask

  task automatic test_game_over();
    int hits;
    hits = 0;
    set_pos(10, 20, 100, 50);
    do_reset();
    set_pos(40, 40, 40, 40);
    cyc();
    run_ticks(1);
    checks++; if (b_hit !== 1'b1) begin errors++; $display("FAIL over_hit got %0d exp 1", b_hit); end
    checks++; if (b_lives !== 3'd0) begin errors++; $display("FAIL over_lives got %0d exp 0", b_lives); end
    checks++; if (b_go !== 1'b1) begin errors++; $display("FAIL over_flag got %0d exp 1", b_go); end
    tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (b_hit || b_resp) hits++;
    end
    tick = 1'b0;
    checks++; if (hits !== 0) begin errors++; $display("FAIL over_rehit got %0d exp 0", hits); end
    checks++; if (b_score !== 16'd0) begin errors++; $display("FAIL over_score got %0d exp 0", b_score); end
    checks++; if (b_lives !== 3'd0) begin errors++; $display("FAIL over_lives_frozen got %0d exp 0", b_lives); end
    do_reset();
    checks++; if (b_lives !== 3'd1) begin errors++; $display("FAIL over_clr_lives got %0d exp 1", b_lives); end
    checks++; if (b_go !== 1'b0) begin errors++; $display("FAIL over_clr_flag got %0d exp 0", b_go); end
  endtask

  task automatic test_window();
    do_reset();
    set_pos(50, 30, 52, 28);
    cyc();
    run_ticks(1);
    checks++; if (a_hit !== 1'b1) begin errors++; $display("FAIL win_corner got %0d exp 1", a_hit); end
    do_reset();
    set_pos(50, 30, 53, 30);
    cyc();
    run_ticks(1);
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL win_dx3 got %0d exp 0", a_hit); end
    checks++; if (a_score !== 16'd1) begin errors++; $display("FAIL win_dx3_score got %0d exp 1", a_score); end
    do_reset();
    set_pos(50, 30, 50, 33);
    cyc();
    run_ticks(1);
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL win_dy3 got %0d exp 0", a_hit); end
    do_reset();
    set_pos(3, 14, 127, 63);
    cyc();
    run_ticks(1);
    checks++; if (a_hit !== 1'b0) begin errors++; $display("FAIL win_nowrap got %0d exp 0", a_hit); end
    do_reset();
    set_pos(92, 60, 92, 60);
    cyc();
    run_ticks(1);
    checks++; if (a_hit !== 1'b1) begin errors++; $display("FAIL win_same got %0d exp 1", a_hit); end
  endtask

  task automatic test_score_sat();
    set_pos(10, 20, 100, 50);
    do_reset();
    cyc();
    run_ticks(20);
    checks++; if (c_score !== 4'd15) begin errors++; $display("FAIL sat_score got %0d exp 15", c_score); end
    checks++; if (a_score !== 16'd20) begin errors++; $display("FAIL score_count got %0d exp 20", a_score); end
    clr  = 1'b1;
    tick = 1'b1;
    cyc();
    clr  = 1'b0;
    tick = 1'b0;
    checks++; if (c_score !== 4'd0) begin errors++; $display("FAIL clr_tick_score got %0d exp 0", c_score); end
    checks++; if (a_score !== 16'd0) begin errors++; $display("FAIL clr_tick_score_a got %0d exp 0", a_score); end
  endtask

`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
  task automatic test_extra_life();
    set_pos(10, 20, 100, 50);
    do_reset();
    cyc();
    run_ticks(5);
    checks++; if (d_lives !== 3'd4) begin errors++; $display("FAIL xl_first got %0d exp 4", d_lives); end
    run_ticks(15);
    checks++; if (d_lives !== 3'd7) begin errors++; $display("FAIL xl_seven got %0d exp 7", d_lives); end
    run_ticks(5);
    checks++; if (d_lives !== 3'd7) begin errors++; $display("FAIL xl_sat got %0d exp 7", d_lives); end
    do_reset();
    run_ticks(4);
    set_pos(40, 40, 40, 40);
    cyc();
    run_ticks(1);
    checks++; if (b_hit !== 1'b1) begin errors++; $display("FAIL xl_hit got %0d exp 1", b_hit); end
    checks++; if (b_lives !== 3'd1) begin errors++; $display("FAIL xl_net_lives got %0d exp 1", b_lives); end
    checks++; if (b_inv !== 1'b1) begin errors++; $display("FAIL xl_invuln got %0d exp 1", b_inv); end
    checks++; if (b_go !== 1'b0) begin errors++; $display("FAIL xl_not_over got %0d exp 0", b_go); end
    run_ticks(1);
    checks++; if (b_lives !== 3'd1) begin errors++; $display("FAIL xl_no_double got %0d exp 1", b_lives); end
    checks++; if (b_score !== 16'd5) begin errors++; $display("FAIL xl_score got %0d exp 5", b_score); end
  endtask
`endif

  initial begin
    test_reset();
    test_collision();
    test_invuln();
    test_clr_mid_invuln();
    test_game_over();
    test_window();
    test_score_sat();
`ifdef BALL_HIT_TRACKER_EXTRA_LIFE_EN
    test_extra_life();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
